alu_unit: RTL and testbench
===========================

# alu_unit

Execution unit at the far end of the RS→ALU issue interface. It accepts one ready RV32I integer, branch or jump operation per cycle from the reservation station and computes it in a single registered stage. It then drives the ALU result broadcast (valid, ROB position, value) that the RS, LSB and ROB snoop. It also reports resolved control-flow outcome (taken flag plus next PC) to the ROB for branch-mispredict detection.

## Interface
- Parameters: none. Widths come from `setsize.v` macros: `DATA_WID`/`ADDR_WID` = 32 bits, `OPCODE_WID` = 7, `FUNCT3_WID` = 3, `ROB_POS_WID` = 4.
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; when low, all state holds
- rollback  in  1  flush from ROB; cancels in-flight result
- alu_en  in  1  issue strobe from RS, one op per asserted cycle
- alu_opcode  in  7  instruction opcode
- alu_funct3  in  3  funct3 field
- alu_funct7  in  1  instruction bit 30 (SUB/SRA select)
- alu_val1  in  32  rs1 operand
- alu_val2  in  32  rs2 operand
- alu_imm  in  32  sign-extended immediate (U-type already shifted)
- alu_pc  in  32  instruction PC
- alu_rob_pos  in  4  destination ROB entry
- alu_result  out  1  broadcast valid, one-cycle pulse per op
- alu_result_rob_pos  out  4  ROB entry of result
- alu_result_val  out  32  rd write value
- alu_result_jump  out  1  control flow taken (JAL, JALR, taken branch)
- alu_result_pc  out  32  resolved next PC (target if taken, else pc+4)

## Operation
- Combinational compute of value/jump/pc from the current inputs; registered into the outputs on the edge where `rdy & alu_en`.
- LUI 0110111: val = imm; jump=0; pc = pc+4.
- AUIPC 0010111: val = pc+imm.
- JAL 1101111: val = pc+4; jump=1; pc = pc+imm.
- JALR 1100111: val = pc+4; jump=1; pc = (val1+imm) & ~1.
- BRANCH 1100011: val = 0. Condition by funct3: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU. Taken: jump=1, pc=pc+imm; else jump=0, pc=pc+4. Other funct3 are never taken.
- OP-IMM 0010011: operand2 = imm. The register-operand group OP (0110011, below) uses operand2 = val2. Both share the same ops:
  - 000 ADD; SUB only for OP with funct7=1.
  - 001 SLL.
  - 010 SLT signed.
  - 011 SLTU.
  - 100 XOR.
  - 101 SRL/SRA by funct7.
  - 110 OR.
  - 111 AND.
  - Shift amount = operand2[4:0].
- All arithmetic is modulo 2^32; no overflow flag.
- Any other opcode: val = 0, jump = 0, pc = pc+4; the result is still broadcast so the ROB entry completes.
- No backpressure toward the RS; every accepted op produces exactly one broadcast.

## Timing
- Latency: op issued at edge N (alu_en high in the cycle before edge N) gives `alu_result`=1 from edge N to N+1, with all fields valid in that cycle.
- Throughput: one op per cycle; back-to-back alu_en gives back-to-back pulses with no bubble.
- `alu_result` is cleared on any rdy-high edge where alu_en=0.
- rdy low: all outputs hold their values, including `alu_result`. Consumers are also rdy-gated, so there is no double consume.
- rst (priority over everything):
  - `alu_result`=0, `alu_result_jump`=0.
  - `alu_result_rob_pos`=0, `alu_result_val`=0, `alu_result_pc`=0.
- rollback (only when rst low):
  - Next edge: `alu_result`=0 and `alu_result_jump`=0; data fields may keep stale values.
  - An op presented in the same cycle as rollback is dropped.
  - rollback acts even when rdy is low, matching the RS flush.
- A result already broadcast before rollback is not retracted.

## Test plan
- ADD/SUB wrap: OP, val1=0x7FFFFFFF, val2=1, funct7=0 -> val 0x80000000. Then funct7=1, val1=0, val2=1 -> val 0xFFFFFFFF, rob_pos echoed, one-cycle `alu_result`.
- Shifts: OP-IMM f3=101, val1=0x80000000, imm=4: funct7=0 -> 0x08000000; funct7=1 -> 0xF8000000. OP SLL with val2=0x21 -> shift by 1.
- Branch signedness: val1=0xFFFFFFFF, val2=1, pc=0x100, imm=0x20:
  - BLT -> jump=1, pc=0x120.
  - BLTU -> jump=0, pc=0x104.
  - Both give val=0.
- JALR: pc=0x200, val1=0x1001, imm=2 -> val 0x204, jump=1, pc 0x1002.
- Pipeline/stall: three consecutive alu_en ops with ROB positions 3, 4, 5 -> pulses on three consecutive cycles. Drop rdy for 2 cycles mid-stream -> outputs frozen, then resume with no op lost or duplicated.
- Flush/reset: alu_en with rollback in the same cycle -> no `alu_result` next cycle. A pending result followed by rst -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/alu_unit.sv
// alu_unit: single-stage RV32I integer/branch/jump execution unit.
// Computes value, taken flag and next PC combinationally from the issued op
// and registers them onto the result broadcast seen by the RS, LSB and ROB.
module alu_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        alu_en,
  input  logic [6:0]  alu_opcode,
  input  logic [2:0]  alu_funct3,
  input  logic        alu_funct7,
  input  logic [31:0] alu_val1,
  input  logic [31:0] alu_val2,
  input  logic [31:0] alu_imm,
  input  logic [31:0] alu_pc,
  input  logic [3:0]  alu_rob_pos,
  output logic        alu_result,
  output logic [3:0]  alu_result_rob_pos,
  output logic [31:0] alu_result_val,
  output logic        alu_result_jump,
  output logic [31:0] alu_result_pc
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic        res_q;
  logic [3:0]  pos_q;
  logic [31:0] val_q, pc_q;
  logic        jump_q;

  logic [31:0] val_d, pc_d, op2, alu_out, pc_plus4;
  logic        jump_d, taken;
  logic [4:0]  shamt;

  assign op2      = (alu_opcode == OP_OP) ? alu_val2 : alu_imm;
  assign shamt    = op2[4:0];
  assign pc_plus4 = alu_pc + 32'd4;

  // Shared integer datapath for OP and OP-IMM
  always_comb begin
    alu_out = '0;
    case (alu_funct3)
      3'b000: alu_out = (alu_opcode == OP_OP && alu_funct7) ? alu_val1 - op2
                                                             : alu_val1 + op2;
      3'b001: alu_out = alu_val1 << shamt;
      3'b010: alu_out = {31'b0, $signed(alu_val1) < $signed(op2)};
      3'b011: alu_out = {31'b0, alu_val1 < op2};
      3'b100: alu_out = alu_val1 ^ op2;
      3'b101: alu_out = alu_funct7 ? 32'($signed(alu_val1) >>> shamt)
                                   : alu_val1 >> shamt;
      3'b110: alu_out = alu_val1 | op2;
      3'b111: alu_out = alu_val1 & op2;
      default: alu_out = '0;
    endcase
  end

  // Branch condition; reserved funct3 encodings are never taken
  always_comb begin
    taken = 1'b0;
    case (alu_funct3)
      3'b000: taken = (alu_val1 == alu_val2);
      3'b001: taken = (alu_val1 != alu_val2);
      3'b100: taken = ($signed(alu_val1) <  $signed(alu_val2));
      3'b101: taken = ($signed(alu_val1) >= $signed(alu_val2));
      3'b110: taken = (alu_val1 <  alu_val2);
      3'b111: taken = (alu_val1 >= alu_val2);
      default: taken = 1'b0;
    endcase
  end

  // Per-opcode result selection; unknown opcodes still complete with val 0
  always_comb begin
    val_d  = '0;
    jump_d = 1'b0;
    pc_d   = pc_plus4;
    case (alu_opcode)
      OP_LUI:   val_d = alu_imm;
      OP_AUIPC: val_d = alu_pc + alu_imm;
      OP_JAL: begin
        val_d  = pc_plus4;
        jump_d = 1'b1;
        pc_d   = alu_pc + alu_imm;
      end
      OP_JALR: begin
        val_d  = pc_plus4;
        jump_d = 1'b1;
        pc_d   = (alu_val1 + alu_imm) & ~32'd1;
      end
      OP_BRANCH: begin
        jump_d = taken;
        pc_d   = taken ? alu_pc + alu_imm : pc_plus4;
      end
      OP_OPIMM, OP_OP: val_d = alu_out;
      default: ;
    endcase
  end

  // Broadcast register: rst > rollback (ignores rdy) > rdy-gated issue
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q  <= 1'b0;
      jump_q <= 1'b0;
      pos_q  <= '0;
      val_q  <= '0;
      pc_q   <= '0;
    end else if (rollback) begin
      res_q  <= 1'b0;
      jump_q <= 1'b0;
    end else if (rdy) begin
      if (alu_en) begin
        res_q  <= 1'b1;
        pos_q  <= alu_rob_pos;
        val_q  <= val_d;
        jump_q <= jump_d;
        pc_q   <= pc_d;
      end else begin
        res_q  <= 1'b0;
      end
    end
  end

  assign alu_result         = res_q;
  assign alu_result_rob_pos = pos_q;
  assign alu_result_val     = val_q;
  assign alu_result_jump    = jump_q;
  assign alu_result_pc      = pc_q;
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed test-plan steps followed by a randomized stream,
// every cycle compared against a behavioural model of the broadcast.
module tb_alu_unit;
  logic        clk = 1'b0;
  logic        rst, rdy, rollback, alu_en, alu_funct7;
  logic [6:0]  alu_opcode;
  logic [2:0]  alu_funct3;
  logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
  logic [3:0]  alu_rob_pos;
  logic        alu_result, alu_result_jump;
  logic [3:0]  alu_result_rob_pos;
  logic [31:0] alu_result_val, alu_result_pc;

  int checks = 0;
  int errors = 0;

  // model of the registered broadcast
  logic        e_res, e_jmp;
  logic [3:0]  e_pos;
  logic [31:0] e_val, e_pc;

  alu_unit dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .alu_en(alu_en),
    .alu_opcode(alu_opcode), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm),
    .alu_pc(alu_pc), .alu_rob_pos(alu_rob_pos),
    .alu_result(alu_result), .alu_result_rob_pos(alu_result_rob_pos),
    .alu_result_val(alu_result_val), .alu_result_jump(alu_result_jump),
    .alu_result_pc(alu_result_pc)
  );

  always #5 clk = ~clk;

  // Reference semantics of one RV32I op, using integer arithmetic
  function automatic void ref_exec(input logic [6:0] op, input logic [2:0] f3,
      input logic f7, input logic [31:0] v1, v2, imm, pc,
      output logic [31:0] val, output logic jmp, output logic [31:0] npc);
    longint unsigned a, b;
    int sa, sb, sh;
    bit t;
    val = 0; jmp = 0; npc = 32'(pc + 4);
    if (op == 7'h37) val = imm;
    else if (op == 7'h17) val = 32'(pc + imm);
    else if (op == 7'h6f) begin val = 32'(pc + 4); jmp = 1; npc = 32'(pc + imm); end
    else if (op == 7'h67) begin
      val = 32'(pc + 4); jmp = 1;
      npc = 32'(v1 + imm); npc[0] = 1'b0;
    end else if (op == 7'h63) begin
      sa = int'(v1); sb = int'(v2);
      t = (f3 == 0) ? (v1 == v2) : (f3 == 1) ? (v1 != v2) :
          (f3 == 4) ? (sa < sb)  : (f3 == 5) ? (sa >= sb) :
          (f3 == 6) ? (v1 < v2)  : (f3 == 7) ? (v1 >= v2) : 1'b0;
      jmp = t;
      if (t) npc = 32'(pc + imm);
    end else if (op == 7'h13 || op == 7'h33) begin
      a  = longint'(v1);
      b  = longint'((op == 7'h33) ? v2 : imm);
      sa = int'(v1); sb = int'(b[31:0]);
      sh = int'(b % 32);
      case (f3)
        0: val = (op == 7'h33 && f7) ? 32'(a + 64'h1_0000_0000 - b) : 32'(a + b);
        1: val = 32'(a * (64'd1 << sh));
        2: val = (sa < sb) ? 1 : 0;
        3: val = (a < b) ? 1 : 0;
        4: val = 32'(a ^ b);
        5: val = f7 ? 32'(sa >>> sh) : 32'(a / (64'd1 << sh));
        6: val = 32'(a | b);
        default: val = 32'(a & b);
      endcase
    end
  endfunction

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock edge: advance the model from the pre-edge inputs, then check
  task automatic tick();
    logic [31:0] v, p;
    logic j;
    @(posedge clk);
    ref_exec(alu_opcode, alu_funct3, alu_funct7, alu_val1, alu_val2, alu_imm, alu_pc, v, j, p);
    if (rst) begin
      e_res = 0; e_jmp = 0; e_pos = 0; e_val = 0; e_pc = 0;
    end else if (rollback) begin
      e_res = 0; e_jmp = 0;
    end else if (rdy) begin
      if (alu_en) begin
        e_res = 1; e_pos = alu_rob_pos; e_val = v; e_jmp = j; e_pc = p;
      end else e_res = 0;
    end
    #1;
    cmp("result", 32'(alu_result), 32'(e_res));
    cmp("rob_pos", 32'(alu_result_rob_pos), 32'(e_pos));
    cmp("val", alu_result_val, e_val);
    cmp("jump", 32'(alu_result_jump), 32'(e_jmp));
    cmp("pc", alu_result_pc, e_pc);
    @(negedge clk);
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
      input logic [31:0] v1, v2, imm, pc, input logic [3:0] pos);
    alu_en = 1; alu_opcode = op; alu_funct3 = f3; alu_funct7 = f7;
    alu_val1 = v1; alu_val2 = v2; alu_imm = imm; alu_pc = pc; alu_rob_pos = pos;
  endtask

  logic [6:0] ops [9] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h13, 7'h33, 7'h33, 7'h13};

  initial begin
    rst = 1; rdy = 1; rollback = 0; alu_en = 0; alu_funct7 = 0;
    alu_opcode = 0; alu_funct3 = 0; alu_val1 = 0; alu_val2 = 0;
    alu_imm = 0; alu_pc = 0; alu_rob_pos = 0;
    e_res = 0; e_jmp = 0; e_pos = 0; e_val = 0; e_pc = 0;
    @(negedge clk);
    tick(); tick();
    rst = 0;

    // ADD / SUB wrap
    issue(7'h33, 3'b000, 0, 32'h7FFFFFFF, 32'd1, 0, 32'h40, 4'd5); tick();
    cmp("add_wrap", alu_result_val, 32'h80000000);
    issue(7'h33, 3'b000, 1, 32'd0, 32'd1, 0, 32'h44, 4'd9); tick();
    cmp("sub_wrap", alu_result_val, 32'hFFFFFFFF);
    cmp("sub_pos", 32'(alu_result_rob_pos), 32'd9);
    alu_en = 0; tick();
    cmp("pulse_clear", 32'(alu_result), 32'd0);

    // Shifts
    issue(7'h13, 3'b101, 0, 32'h80000000, 0, 32'd4, 0, 4'd1); tick();
    cmp("srli", alu_result_val, 32'h08000000);
    issue(7'h13, 3'b101, 1, 32'h80000000, 0, 32'd4, 0, 4'd2); tick();
    cmp("srai", alu_result_val, 32'hF8000000);
    issue(7'h33, 3'b001, 0, 32'd1, 32'h21, 0, 0, 4'd3); tick();
    cmp("sll_mask", alu_result_val, 32'd2);

    // Branch signedness
    issue(7'h63, 3'b100, 0, 32'hFFFFFFFF, 32'd1, 32'h20, 32'h100, 4'd4); tick();
    cmp("blt_jump", 32'(alu_result_jump), 32'd1);
    cmp("blt_pc", alu_result_pc, 32'h120);
    cmp("blt_val", alu_result_val, 32'd0);
    issue(7'h63, 3'b110, 0, 32'hFFFFFFFF, 32'd1, 32'h20, 32'h100, 4'd5); tick();
    cmp("bltu_jump", 32'(alu_result_jump), 32'd0);
    cmp("bltu_pc", alu_result_pc, 32'h104);

    // JALR
    issue(7'h67, 3'b000, 0, 32'h1001, 0, 32'd2, 32'h200, 4'd6); tick();
    cmp("jalr_val", alu_result_val, 32'h204);
    cmp("jalr_pc", alu_result_pc, 32'h1002);

    // Back-to-back with a 2-cycle rdy stall
    issue(7'h13, 3'b000, 0, 32'd10, 0, 32'd3, 0, 4'd3); tick();
    cmp("pipe3", 32'(alu_result_rob_pos), 32'd3);
    issue(7'h13, 3'b000, 0, 32'd10, 0, 32'd4, 0, 4'd4); tick();
    cmp("pipe4", 32'(alu_result_rob_pos), 32'd4);
    issue(7'h13, 3'b000, 0, 32'd10, 0, 32'd5, 0, 4'd5);
    rdy = 0; tick(); tick();
    cmp("stall_hold", 32'(alu_result_rob_pos), 32'd4);
    cmp("stall_res", 32'(alu_result), 32'd1);
    rdy = 1; tick();
    cmp("pipe5", alu_result_val, 32'd15);
    alu_en = 0; tick();

    // Flush and reset
    issue(7'h6f, 3'b000, 0, 0, 0, 32'h40, 32'h80, 4'd7); rollback = 1; tick();
    cmp("rollback_drop", 32'(alu_result), 32'd0);
    rollback = 0; tick();
    alu_en = 0; rst = 1; tick();
    cmp("rst_val", alu_result_val, 32'd0);
    rst = 0;

    // Randomized stream
    for (int i = 0; i < 600; i++) begin
      issue(($urandom % 8 == 0) ? 7'($urandom) : ops[$urandom % 9], 3'($urandom),
            1'($urandom), $urandom, ($urandom % 4 == 0) ? 32'($urandom % 40) : $urandom,
            ($urandom % 2) ? 32'($signed(12'($urandom))) : $urandom, $urandom, 4'($urandom));
      if ($urandom % 8 == 0) alu_val2 = alu_val1;
      alu_en   = ($urandom % 4) != 0;
      rdy      = ($urandom % 5) != 0;
      rollback = ($urandom % 20) == 0;
      rst      = ($urandom % 70) == 0;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
